// File: rtl/ids_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : ids_detector_if
// Brief    : ROM sample / address / alarm bundle between the ROM and ids_detector
// Revision : 1.0  initial release
// ============================================================================
interface ids_detector_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] E_in;
    logic [DATA_W-1:0] O_in;
    logic              data_rdy;
    logic [ADDR_W-1:0] addra_out;
    logic [ADDR_W-1:0] addrb_out;
    logic              is_attacked;

    modport master (
        output E_in, O_in, data_rdy,
        input  addra_out, addrb_out, is_attacked
    );

    modport slave (
        input  E_in, O_in, data_rdy,
        output addra_out, addrb_out, is_attacked
    );
endinterface
`default_nettype wire

// File: rtl/ids_detector.sv
`default_nettype none
// ============================================================================
// Module   : ids_detector
// Brief    : Sweeps a dual-port sample ROM and raises a sticky alarm after
//            CONSEC_LIMIT consecutive samples with |E-O| > DIFF_THRESH.
// Revision : 1.0  initial release
// ============================================================================
module ids_detector #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int READ_LAT     = 1,
    parameter int DIFF_THRESH  = 64,
    parameter int CONSEC_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    ids_detector_if.slave bus
);
    localparam int                 c_cnt_w  = $clog2(CONSEC_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit  = c_cnt_w'(CONSEC_LIMIT);
    localparam logic [DATA_W-1:0]  c_thresh = DATA_W'(DIFF_THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [READ_LAT-1:0] r_valid;
    logic [READ_LAT-1:0] w_valid_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                r_attacked;
    logic [DATA_W-1:0]   w_diff;
    logic                w_anomaly;
    logic                w_cmp_en;

    // Valid pipe mirrors the ROM read latency so the tail lines up with E_in/O_in.
    generate
        if (READ_LAT == 1) begin : g_pipe_single
            assign w_valid_next = bus.data_rdy;
        end else begin : g_pipe_multi
            assign w_valid_next = {r_valid[READ_LAT-2:0], bus.data_rdy};
        end
    endgenerate

    assign w_diff    = (bus.E_in >= bus.O_in) ? (bus.E_in - bus.O_in) : (bus.O_in - bus.E_in);
    assign w_anomaly = (w_diff > c_thresh);
    // A non-idle state is implied by a valid tail; the term keeps the two views tied together.
    assign w_cmp_en  = r_valid[READ_LAT-1] && (r_state != S_IDLE);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_cmp_en) begin
            if (w_anomaly) begin
                w_cnt_next = (r_cnt == c_limit) ? r_cnt : (r_cnt + c_cnt_w'(1));
            end else begin
                w_cnt_next = '0;
            end
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (bus.data_rdy) begin
            w_state_next = S_RUN;
        end else if (|w_valid_next) begin
            w_state_next = S_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_valid    <= '0;
            r_cnt      <= '0;
            r_attacked <= 1'b0;
        end else begin
            if (bus.data_rdy) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            r_valid <= w_valid_next;
            r_cnt   <= w_cnt_next;
            if (w_cmp_en && (w_cnt_next == c_limit)) begin
                r_attacked <= 1'b1;
            end
        end
    end

    assign bus.addra_out   = r_addr;
    assign bus.addrb_out   = r_addr;
    assign bus.is_attacked = r_attacked;

endmodule
`default_nettype wire

// File: tb/tb_ids_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ids_detector
// Brief    : Directed vector table plus hand-written sequences for ids_detector.
// Revision : 1.0  initial release
// ============================================================================
module tb_ids_detector;
    localparam int c_addr_w = 8;
    localparam int c_data_w = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [c_data_w-1:0] e_mem [256];
    logic [c_data_w-1:0] o_mem [256];

    ids_detector_if #(.ADDR_W(c_addr_w), .DATA_W(c_data_w)) bus ();

    ids_detector #(
        .ADDR_W       (c_addr_w),
        .DATA_W       (c_data_w),
        .READ_LAT     (1),
        .DIFF_THRESH  (64),
        .CONSEC_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model with one clock of read latency
    always @(posedge clk) begin
        bus.E_in <= e_mem[bus.addra_out];
        bus.O_in <= o_mem[bus.addrb_out];
    end

    typedef struct {
        logic [c_data_w-1:0] e;
        logic [c_data_w-1:0] o;
        int                  len;
        logic                exp_flag;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rom_clean();
        for (int i = 0; i < 256; i++) begin
            e_mem[i] = 16'(i * 7);
            o_mem[i] = 16'(i * 7);
        end
    endtask

    task automatic rom_anom(input int a, input logic [c_data_w-1:0] e, input logic [c_data_w-1:0] o);
        e_mem[a] = e;
        o_mem[a] = o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        bus.data_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while ((int'(bus.addra_out) != target) && (n < 600)) begin
            @(negedge clk);
            n++;
        end
        check("run_to_addr", 32'(bus.addra_out), 32'(target));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        bus.data_rdy = 1'b0;
        rom_clean();

        vecs[0] = '{e: 16'd1000,  o: 16'd1064,  len: 4, exp_flag: 1'b0};
        vecs[1] = '{e: 16'd1000,  o: 16'd1065,  len: 4, exp_flag: 1'b1};
        vecs[2] = '{e: 16'd1065,  o: 16'd1000,  len: 4, exp_flag: 1'b1};
        vecs[3] = '{e: 16'd1064,  o: 16'd1000,  len: 4, exp_flag: 1'b0};
        vecs[4] = '{e: 16'd0,     o: 16'd5000,  len: 3, exp_flag: 1'b0};
        vecs[5] = '{e: 16'd0,     o: 16'hFFFF,  len: 5, exp_flag: 1'b1};
        vecs[6] = '{e: 16'hFFFF,  o: 16'd0,     len: 4, exp_flag: 1'b1};
        vecs[7] = '{e: 16'd4242,  o: 16'd4242,  len: 6, exp_flag: 1'b0};

        // Reset held with data_rdy high
        @(negedge clk);
        bus.data_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_addra", 32'(bus.addra_out), 32'd0);
            check("reset_addrb", 32'(bus.addrb_out), 32'd0);
            check("reset_flag", 32'(bus.is_attacked), 32'd0);
        end

        // Clean sweep across the wrap
        do_reset();
        bus.data_rdy = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            check("sweep_addr", 32'(bus.addra_out), 32'(k % 256));
            check("sweep_addrb", 32'(bus.addrb_out), 32'(k % 256));
            check("sweep_flag", 32'(bus.is_attacked), 32'd0);
        end

        // Vector table: anomaly run of len samples at addr 10.. with (e,o)
        for (int v = 0; v < 8; v++) begin
            rom_clean();
            for (int k = 0; k < vecs[v].len; k++) rom_anom(10 + k, vecs[v].e, vecs[v].o);
            do_reset();
            bus.data_rdy = 1'b1;
            repeat (30) @(negedge clk);
            check("vec_addr", 32'(bus.addra_out), 32'd30);
            check("vec_flag", 32'(bus.is_attacked), 32'(vecs[v].exp_flag));
        end

        // Exact latency: run at 10..13 with diff 65 flags on the edge after addr passes 14
        rom_clean();
        for (int k = 10; k <= 13; k++) rom_anom(k, 16'd1000, 16'd1065);
        do_reset();
        bus.data_rdy = 1'b1;
        run_to(14);
        check("lat_flag_before", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("lat_flag_after", 32'(bus.is_attacked), 32'd1);

        // Broken runs of three never flag; extending the second run does
        rom_clean();
        for (int k = 30; k <= 32; k++) rom_anom(k, 16'd10, 16'd900);
        for (int k = 40; k <= 42; k++) rom_anom(k, 16'd10, 16'd900);
        do_reset();
        bus.data_rdy = 1'b1;
        run_to(60);
        check("runlen_no_flag", 32'(bus.is_attacked), 32'd0);
        rom_anom(43, 16'd900, 16'd10);
        do_reset();
        bus.data_rdy = 1'b1;
        run_to(44);
        check("runlen43_before", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("runlen43_after", 32'(bus.is_attacked), 32'd1);

        // Pause mid-run: count survives the gap
        rom_clean();
        for (int k = 50; k <= 53; k++) rom_anom(k, 16'd2000, 16'd100);
        do_reset();
        bus.data_rdy = 1'b1;
        run_to(52);
        bus.data_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pause_addr", 32'(bus.addra_out), 32'd52);
            check("pause_flag", 32'(bus.is_attacked), 32'd0);
        end
        bus.data_rdy = 1'b1;
        @(negedge clk);
        check("resume_addr53", 32'(bus.addra_out), 32'd53);
        check("resume_flag53", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("resume_flag54", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("resume_addr55", 32'(bus.addra_out), 32'd55);
        check("resume_flag55", 32'(bus.is_attacked), 32'd1);

        // Asynchronous reset between edges
        rom_clean();
        for (int k = 110; k <= 113; k++) rom_anom(k, 16'd300, 16'd3000);
        do_reset();
        bus.data_rdy = 1'b1;
        run_to(120);
        check("areset_pre_flag", 32'(bus.is_attacked), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("areset_addr", 32'(bus.addra_out), 32'd0);
        check("areset_flag", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("areset_hold_addr", 32'(bus.addra_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("restart_addr", 32'(bus.addra_out), 32'd1);
        run_to(114);
        check("restart_flag_before", 32'(bus.is_attacked), 32'd0);
        @(negedge clk);
        check("restart_flag_after", 32'(bus.is_attacked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
